axis_spi_master: RTL and testbench

AXIS_SPI_MASTER -- requirements
Module: axis_spi_master

---
 rtl/axis_spi_master.sv | 214 +++++++++++++++++++++
 tb/tb_axis_spi_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_spi_master.sv
// AXI-stream to SPI master, mode 0, MSB first. Each input beat is shifted out on
// mosi while miso is captured into an output beat; tlast closes the chip-select frame.
module axis_spi_master #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  cs,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    input  logic [15:0]           prescale,
    output logic                  busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t                  state_r, state_s;
    logic [15:0]             cnt_r, cnt_s;
    logic [15:0]             pre_r, pre_s;
    logic [BW-1:0]           bit_r, bit_s;
    logic [DATA_WIDTH-1:0]   tx_r, tx_s;
    logic [DATA_WIDTH-1:0]   rx_r, rx_s;
    logic                    last_r, last_s;
    logic                    sck_r, sck_s;
    logic                    cs_r, cs_s;
    logic                    mosi_r, mosi_s;
    logic                    tready_r, tready_s;
    logic                    busy_r, busy_s;
    logic                    ovalid_r, ovalid_s;
    logic [DATA_WIDTH-1:0]   odata_r, odata_s;
    logic                    olast_r, olast_s;
    logic                    cnt_end_s;
    logic                    accept_s;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pre_s     = pre_r;
        bit_s     = bit_r;
        tx_s      = tx_r;
        rx_s      = rx_r;
        last_s    = last_r;
        sck_s     = sck_r;
        cs_s      = cs_r;
        mosi_s    = mosi_r;
        ovalid_s  = ovalid_r;
        odata_s   = odata_r;
        olast_s   = olast_r;
        cnt_end_s = (cnt_r == (pre_r - 16'd1));
        accept_s  = input_axis_tvalid && tready_r;

        if (ovalid_r && output_axis_tready) begin
            ovalid_s = 1'b0;
        end else begin
            ovalid_s = ovalid_r;
        end

        case (state_r)
            ST_IDLE: begin
                cs_s  = 1'b1;
                sck_s = 1'b0;
                if (accept_s) begin
                    tx_s    = input_axis_tdata;
                    last_s  = input_axis_tlast;
                    pre_s   = (prescale == 16'd0) ? 16'd1 : prescale;
                    mosi_s  = input_axis_tdata[DATA_WIDTH-1];
                    cs_s    = 1'b0;
                    cnt_s   = 16'd0;
                    bit_s   = '0;
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_end_s) begin
                    cnt_s   = 16'd0;
                    state_s = ST_SHIFT;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_SHIFT: begin
                if (!cnt_end_s) begin
                    cnt_s = cnt_r + 16'd1;
                end else if (!sck_r) begin
                    // Rising edge: miso is captured on the same clk cycle sck goes high.
                    cnt_s = 16'd0;
                    sck_s = 1'b1;
                    rx_s  = {rx_r[DATA_WIDTH-2:0], miso};
                end else begin
                    cnt_s = 16'd0;
                    sck_s = 1'b0;
                    if (bit_r == BIT_LAST) begin
                        ovalid_s = 1'b1;
                        odata_s  = rx_r;
                        olast_s  = last_r;
                        state_s  = last_r ? ST_HOLD : ST_WAIT;
                    end else begin
                        bit_s  = bit_r + {{(BW-1){1'b0}}, 1'b1};
                        tx_s   = {tx_r[DATA_WIDTH-2:0], 1'b0};
                        mosi_s = tx_r[DATA_WIDTH-2];
                    end
                end
            end
            ST_WAIT: begin
                // Next word of the frame goes straight to SHIFT; cs is still low.
                if (accept_s) begin
                    tx_s    = input_axis_tdata;
                    last_s  = input_axis_tlast;
                    mosi_s  = input_axis_tdata[DATA_WIDTH-1];
                    cnt_s   = 16'd0;
                    bit_s   = '0;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (cnt_end_s) begin
                    cnt_s   = 16'd0;
                    cs_s    = 1'b1;
                    state_s = ST_GAP;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_end_s) begin
                    cnt_s   = 16'd0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            default: begin
                cs_s    = 1'b1;
                sck_s   = 1'b0;
                cnt_s   = 16'd0;
                state_s = ST_IDLE;
            end
        endcase

        tready_s = ((state_s == ST_IDLE) || (state_s == ST_WAIT)) && !ovalid_s;
        busy_s   = (state_s != ST_IDLE);
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 16'd0;
            pre_r    <= 16'd1;
            bit_r    <= '0;
            tx_r     <= '0;
            rx_r     <= '0;
            last_r   <= 1'b0;
            sck_r    <= 1'b0;
            cs_r     <= 1'b1;
            mosi_r   <= 1'b0;
            tready_r <= 1'b0;
            busy_r   <= 1'b0;
            ovalid_r <= 1'b0;
            odata_r  <= '0;
            olast_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            pre_r    <= pre_s;
            bit_r    <= bit_s;
            tx_r     <= tx_s;
            rx_r     <= rx_s;
            last_r   <= last_s;
            sck_r    <= sck_s;
            cs_r     <= cs_s;
            mosi_r   <= mosi_s;
            tready_r <= tready_s;
            busy_r   <= busy_s;
            ovalid_r <= ovalid_s;
            odata_r  <= odata_s;
            olast_r  <= olast_s;
        end
    end

    assign input_axis_tready  = tready_r;
    assign output_axis_tdata  = odata_r;
    assign output_axis_tvalid = ovalid_r;
    assign output_axis_tlast  = olast_r;
    assign cs                 = cs_r;
    assign sck                = sck_r;
    assign mosi               = mosi_r;
    assign busy               = busy_r;

endmodule

// File: tb/tb_axis_spi_master.sv
// Directed bench for axis_spi_master: an SPI mode-0 slave model feeds miso and
// records mosi; each task checks one behaviour against hand-computed values.
module tb_axis_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  input_axis_tdata = 8'h00;
    logic        input_axis_tvalid = 1'b0;
    logic        input_axis_tready;
    logic        input_axis_tlast = 1'b0;
    logic [7:0]  output_axis_tdata;
    logic        output_axis_tvalid;
    logic        output_axis_tready = 1'b1;
    logic        output_axis_tlast;
    logic        cs, sck, mosi, miso;
    logic [15:0] prescale = 16'd2;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    // slave model and monitors
    logic       loop_en = 1'b0;
    logic       slv_miso = 1'b0;
    logic [7:0] slv_sh = 8'h00;
    logic [7:0] slv_q[$];
    logic       preloaded = 1'b0;
    int         slv_bits = 0;
    logic [7:0] rx_mosi = 8'h00;
    logic [7:0] mosi_q[$];
    logic [8:0] out_q[$];
    int         sck_rises = 0;
    int         cs_rises = 0;
    int         cs_low_cyc = 0;
    int         acc_cnt = 0;
    time        last_rise_t = 0;
    time        per_min = 0;
    time        per_max = 0;

    assign miso = loop_en ? mosi : slv_miso;

    axis_spi_master #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .input_axis_tdata(input_axis_tdata), .input_axis_tvalid(input_axis_tvalid),
        .input_axis_tready(input_axis_tready), .input_axis_tlast(input_axis_tlast),
        .output_axis_tdata(output_axis_tdata), .output_axis_tvalid(output_axis_tvalid),
        .output_axis_tready(output_axis_tready), .output_axis_tlast(output_axis_tlast),
        .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
        .prescale(prescale), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic slv_load();
        if (slv_q.size() > 0) slv_sh = slv_q.pop_front();
        else slv_sh = 8'h00;
        slv_miso = slv_sh[7];
    endtask

    always @(posedge sck) begin
        sck_rises++;
        rx_mosi = {rx_mosi[6:0], mosi};
        slv_bits++;
        if (last_rise_t != 0) begin
            if (per_min == 0 || ($time - last_rise_t) < per_min) per_min = $time - last_rise_t;
            if (($time - last_rise_t) > per_max) per_max = $time - last_rise_t;
        end
        last_rise_t = $time;
    end

    always @(negedge sck) begin
        if (slv_bits == 8) begin
            mosi_q.push_back(rx_mosi);
            slv_bits = 0;
            slv_load();
            preloaded = 1'b1;
        end else begin
            slv_sh = {slv_sh[6:0], 1'b0};
            slv_miso = slv_sh[7];
        end
    end

    always @(negedge cs) begin
        if (!preloaded) slv_load();
        preloaded = 1'b0;
    end

    always @(posedge cs) begin
        slv_bits = 0;
        cs_rises++;
    end

    always @(negedge clk) begin
        if (cs === 1'b0) cs_low_cyc++;
        if (input_axis_tvalid && input_axis_tready) acc_cnt++;
        if (output_axis_tvalid && output_axis_tready) out_q.push_back({output_axis_tlast, output_axis_tdata});
    end

    task automatic clear_mon();
        mosi_q.delete(); out_q.delete();
        sck_rises = 0; cs_rises = 0; cs_low_cyc = 0; acc_cnt = 0;
        last_rise_t = 0; per_min = 0; per_max = 0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic l, output bit ok);
        ok = 1'b0;
        input_axis_tdata = d; input_axis_tlast = l; input_axis_tvalid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (input_axis_tready === 1'b1) begin ok = 1'b1; break; end
        end
        #1 input_axis_tvalid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (cs !== 1'b1) $display("FAIL rst_cs got %b want 1", cs); else n_pass++;
        n_checks++; if (sck !== 1'b0) $display("FAIL rst_sck got %b want 0", sck); else n_pass++;
        n_checks++; if (mosi !== 1'b0) $display("FAIL rst_mosi got %b want 0", mosi); else n_pass++;
        n_checks++; if (input_axis_tready !== 1'b0) $display("FAIL rst_tready got %b want 0", input_axis_tready); else n_pass++;
        n_checks++; if ({output_axis_tvalid, output_axis_tlast, output_axis_tdata} !== 10'd0)
            $display("FAIL rst_out got %b/%b/%h want 0/0/00", output_axis_tvalid, output_axis_tlast, output_axis_tdata); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (input_axis_tready !== 1'b0) $display("FAIL rel_tready_early got %b want 0", input_axis_tready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (input_axis_tready !== 1'b1) $display("FAIL rel_tready got %b want 1", input_axis_tready); else n_pass++;
    endtask

    task automatic test_single();
        bit ok;
        clear_mon(); prescale = 16'd2; output_axis_tready = 1'b1;
        slv_q.delete(); slv_q.push_back(8'h3C); preloaded = 1'b0;
        send_word(8'hA5, 1'b1, ok);
        prescale = 16'd5;
        n_checks++; if (!ok) $display("FAIL single_accept got timeout want accept"); else n_pass++;
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL single_idle got timeout want idle"); else n_pass++;
        n_checks++; if (mosi_q.size() != 1 || mosi_q[0] !== 8'hA5) $display("FAIL single_mosi got n=%0d first=%h want 1 word a5", mosi_q.size(), (mosi_q.size() > 0) ? mosi_q[0] : 8'hxx); else n_pass++;
        n_checks++; if (sck_rises != 8) $display("FAIL single_sck_pulses got %0d want 8", sck_rises); else n_pass++;
        n_checks++; if (per_min != 40 || per_max != 40) $display("FAIL single_sck_period got %0t..%0t want 40", per_min, per_max); else n_pass++;
        n_checks++; if (out_q.size() != 1 || out_q[0] !== 9'h13C) $display("FAIL single_out got n=%0d first=%h want 1 beat 13c", out_q.size(), (out_q.size() > 0) ? out_q[0] : 9'hxxx); else n_pass++;
        n_checks++; if (cs_low_cyc != 36) $display("FAIL single_cs_low got %0d want 36", cs_low_cyc); else n_pass++;
        prescale = 16'd2;
    endtask

    task automatic test_multiword();
        bit ok;
        int n_ok = 0;
        clear_mon(); prescale = 16'd1; output_axis_tready = 1'b1;
        slv_q.delete(); slv_q.push_back(8'h11); slv_q.push_back(8'h22); slv_q.push_back(8'h33); preloaded = 1'b0;
        send_word(8'h01, 1'b0, ok); if (ok) n_ok++;
        send_word(8'h02, 1'b0, ok); if (ok) n_ok++;
        send_word(8'h03, 1'b1, ok); if (ok) n_ok++;
        n_checks++; if (n_ok != 3) $display("FAIL multi_accept got %0d want 3", n_ok); else n_pass++;
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL multi_idle got timeout want idle"); else n_pass++;
        n_checks++; if (cs_rises != 1) $display("FAIL multi_cs_continuous got %0d rises want 1", cs_rises); else n_pass++;
        n_checks++; if (out_q.size() != 3) $display("FAIL multi_out_count got %0d want 3", out_q.size()); else n_pass++;
        if (out_q.size() == 3) begin
            n_checks++; if (out_q[0] !== 9'h011) $display("FAIL multi_out0 got %h want 011", out_q[0]); else n_pass++;
            n_checks++; if (out_q[1] !== 9'h022) $display("FAIL multi_out1 got %h want 022", out_q[1]); else n_pass++;
            n_checks++; if (out_q[2] !== 9'h133) $display("FAIL multi_out2 got %h want 133", out_q[2]); else n_pass++;
        end
        n_checks++; if (mosi_q.size() != 3 || mosi_q[0] !== 8'h01 || mosi_q[1] !== 8'h02 || mosi_q[2] !== 8'h03)
            $display("FAIL multi_mosi got n=%0d want 01 02 03", mosi_q.size()); else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        clear_mon(); prescale = 16'd1; output_axis_tready = 1'b0;
        slv_q.delete(); slv_q.push_back(8'hC3); slv_q.push_back(8'h96); preloaded = 1'b0;
        send_word(8'hAA, 1'b0, ok);
        n_checks++; if (!ok) $display("FAIL stall_first_accept got timeout want accept"); else n_pass++;
        input_axis_tdata = 8'h55; input_axis_tlast = 1'b1; input_axis_tvalid = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        n_checks++; if (acc_cnt != 1) $display("FAIL stall_accepts got %0d want 1", acc_cnt); else n_pass++;
        n_checks++; if (sck_rises != 8 || sck !== 1'b0) $display("FAIL stall_sck got %0d rises sck=%b want 8/0", sck_rises, sck); else n_pass++;
        n_checks++; if (cs !== 1'b0 || busy !== 1'b1) $display("FAIL stall_cs got cs=%b busy=%b want 0/1", cs, busy); else n_pass++;
        n_checks++; if (output_axis_tvalid !== 1'b1 || output_axis_tdata !== 8'hC3 || output_axis_tlast !== 1'b0)
            $display("FAIL stall_out_held got %b/%h/%b want 1/c3/0", output_axis_tvalid, output_axis_tdata, output_axis_tlast); else n_pass++;
        output_axis_tready = 1'b1;
        send_word(8'h55, 1'b1, ok);
        n_checks++; if (!ok) $display("FAIL stall_second_accept got timeout want accept"); else n_pass++;
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL stall_idle got timeout want idle"); else n_pass++;
        n_checks++; if (out_q.size() != 2 || out_q[0] !== 9'h0C3 || out_q[1] !== 9'h196)
            $display("FAIL stall_out got n=%0d want 0c3 196", out_q.size()); else n_pass++;
        n_checks++; if (mosi_q.size() != 2 || mosi_q[0] !== 8'hAA || mosi_q[1] !== 8'h55)
            $display("FAIL stall_mosi got n=%0d want aa 55", mosi_q.size()); else n_pass++;
    endtask

    task automatic test_prescale0();
        bit ok;
        clear_mon(); prescale = 16'd0; output_axis_tready = 1'b1;
        slv_q.delete(); slv_q.push_back(8'hE7); preloaded = 1'b0;
        send_word(8'h81, 1'b1, ok);
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL p0_idle got timeout want idle"); else n_pass++;
        n_checks++; if (per_min != 20 || per_max != 20) $display("FAIL p0_sck_period got %0t..%0t want 20", per_min, per_max); else n_pass++;
        n_checks++; if (cs_low_cyc != 18) $display("FAIL p0_cs_low got %0d want 18", cs_low_cyc); else n_pass++;
        n_checks++; if (out_q.size() != 1 || out_q[0] !== 9'h1E7) $display("FAIL p0_out got n=%0d want 1e7", out_q.size()); else n_pass++;
        n_checks++; if (mosi_q.size() != 1 || mosi_q[0] !== 8'h81) $display("FAIL p0_mosi got n=%0d want 81", mosi_q.size()); else n_pass++;
    endtask

    task automatic test_reset_abort();
        bit ok;
        bit hit = 1'b0;
        clear_mon(); prescale = 16'd2; output_axis_tready = 1'b1;
        slv_q.delete(); slv_q.push_back(8'hFF); preloaded = 1'b0;
        send_word(8'h3C, 1'b1, ok);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (sck_rises >= 4) begin hit = 1'b1; break; end
        end
        n_checks++; if (!hit) $display("FAIL abort_reach_4th_rise got timeout want rise"); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (cs !== 1'b1 || sck !== 1'b0) $display("FAIL abort_async got cs=%b sck=%b want 1/0", cs, sck); else n_pass++;
        repeat (40) @(posedge clk);
        #1;
        n_checks++; if (out_q.size() != 0 || output_axis_tvalid !== 1'b0 || output_axis_tdata !== 8'h00)
            $display("FAIL abort_no_output got n=%0d valid=%b data=%h want 0/0/00", out_q.size(), output_axis_tvalid, output_axis_tdata); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        slv_q.delete(); slv_q.push_back(8'hA6); preloaded = 1'b0;
        send_word(8'h5A, 1'b1, ok);
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL abort_next_idle got timeout want idle"); else n_pass++;
        n_checks++; if (out_q.size() != 1 || out_q[0] !== 9'h1A6) $display("FAIL abort_next_out got n=%0d want 1a6", out_q.size()); else n_pass++;
        n_checks++; if (mosi_q.size() != 1 || mosi_q[0] !== 8'h5A) $display("FAIL abort_next_mosi got n=%0d want 5a", mosi_q.size()); else n_pass++;
    endtask

    task automatic test_loopback();
        bit ok;
        logic [8:0] exp_q[$];
        logic [8:0] got;
        logic [7:0] d;
        loop_en = 1'b1; output_axis_tready = 1'b1;
        for (int p = 1; p <= 5; p++) begin
            clear_mon(); exp_q.delete();
            prescale = 16'(p);
            for (int w = 0; w < 3; w++) begin
                d = 8'($urandom_range(0, 255));
                exp_q.push_back({(w == 2), d});
                send_word(d, (w == 2), ok);
            end
            wait_idle(ok);
            n_checks++; if (!ok || out_q.size() != 3) $display("FAIL loop_count p=%0d got %0d want 3", p, out_q.size()); else n_pass++;
            for (int i = 0; i < 3; i++) begin
                got = (i < out_q.size()) ? out_q[i] : 9'bx;
                n_checks++; if (got !== exp_q[i]) $display("FAIL loop_word p=%0d i=%0d got %h want %h", p, i, got, exp_q[i]); else n_pass++;
            end
        end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multiword();
        test_stall();
        test_prescale0();
        test_reset_abort();
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
